// File: rtl/irq_req_ctrl.sv
// ============================================================================
// Module   : irq_req_ctrl
// Brief    : Interrupt request front end around an external 8-to-3 priority
//            encoder: sync, pend, enable-gate, present vector, clear on ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_req_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] EDGE_MODE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_raw,
  input  logic       en_wr,
  input  logic [7:0] en_wdata,
  output logic [7:0] irq_en,
  output logic [7:0] pending,
  output logic [7:0] pe_in_n,
  output logic       pe_en_n,
  input  logic [2:0] pe_out_n,
  input  logic       pe_gs_n,
  output logic       vec_valid,
  output logic [2:0] vec_id,
  input  logic       vec_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t                       r_state;
  logic [SYNC_STAGES-1:0][7:0]  r_sync;
  logic [7:0]                   r_s_d;
  logic [7:0]                   r_set;
  logic [7:0]                   r_pending;
  logic [7:0]                   r_irq_en;
  logic                         r_vec_valid;
  logic [2:0]                   r_vec_id;

  logic [7:0] w_s;
  logic [7:0] w_set;
  logic [7:0] w_clr;

  assign w_s   = r_sync[SYNC_STAGES-1];
  // Edge channels need a 0->1 transition; level channels set while high.
  assign w_set = w_s & (~EDGE_MODE | ~r_s_d);
  assign w_clr = (r_state == ST_PRESENT && vec_ready) ? (8'b1 << r_vec_id) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_s_d     <= 8'h00;
      r_set     <= 8'h00;
      r_pending <= 8'h00;
      r_irq_en  <= 8'h00;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], irq_raw};
      r_s_d     <= w_s;
      r_set     <= w_set;
      // Set is applied after clear so a same-cycle set keeps the bit pending.
      r_pending <= (r_pending & ~w_clr) | r_set;
      if (en_wr) begin
        r_irq_en <= en_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_vec_valid <= 1'b0;
      r_vec_id    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!pe_gs_n) begin
            r_vec_id    <= ~pe_out_n;
            r_vec_valid <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (vec_ready) begin
            r_vec_valid <= 1'b0;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_vec_valid <= 1'b0;
        end
      endcase
    end
  end

  // Encoder is frozen outside IDLE so the presented vector cannot shift.
  assign pe_in_n   = ~(r_pending & r_irq_en);
  assign pe_en_n   = (r_state != ST_IDLE);
  assign irq_en    = r_irq_en;
  assign pending   = r_pending;
  assign vec_valid = r_vec_valid;
  assign vec_id    = r_vec_id;

endmodule

`default_nettype wire

// File: tb/tb_irq_req_ctrl.sv
// ============================================================================
// Module   : tb_irq_req_ctrl
// Brief    : Self-checking bench for irq_req_ctrl with a behavioural encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_raw;
  logic       en_wr;
  logic [7:0] en_wdata;
  logic [7:0] irq_en;
  logic [7:0] pending;
  logic [7:0] pe_in_n;
  logic       pe_en_n;
  logic [2:0] pe_out_n;
  logic       pe_gs_n;
  logic       vec_valid;
  logic [2:0] vec_id;
  logic       vec_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Channel 5 is level-triggered, all others rising-edge.
  irq_req_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(8'hDF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_raw   (irq_raw),
    .en_wr     (en_wr),
    .en_wdata  (en_wdata),
    .irq_en    (irq_en),
    .pending   (pending),
    .pe_in_n   (pe_in_n),
    .pe_en_n   (pe_en_n),
    .pe_out_n  (pe_out_n),
    .pe_gs_n   (pe_gs_n),
    .vec_valid (vec_valid),
    .vec_id    (vec_id),
    .vec_ready (vec_ready)
  );

  // Behavioural 8-to-3 priority encoder, active-low, higher index wins.
  always_comb begin
    pe_out_n = 3'b111;
    pe_gs_n  = 1'b1;
    if (!pe_en_n) begin
      for (int i = 0; i < 8; i++) begin
        if (!pe_in_n[i]) begin
          pe_out_n = ~i[2:0];
          pe_gs_n  = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] raw;
    logic       enw;
    logic [7:0] enwd;
    logic       rdy;
    logic       ev;
    logic [2:0] eid;
    logic [7:0] epend;
    logic       epen;
    logic [7:0] epin;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] raw, logic enw, logic [7:0] enwd, logic rdy,
                              logic ev, logic [2:0] eid, logic [7:0] epend,
                              logic epen, logic [7:0] epin);
    vec_t v;
    v.raw = raw; v.enw = enw; v.enwd = enwd; v.rdy = rdy;
    v.ev = ev; v.eid = eid; v.epend = epend; v.epen = epen; v.epin = epin;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] raw, input logic enw, input logic [7:0] enwd,
                      input logic rdy);
    irq_raw   = raw;
    en_wr     = enw;
    en_wdata  = enwd;
    vec_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  int last_rise;
  int rises;
  logic prev_valid;
  bit got;

  initial begin
    rst_n = 1'b0; irq_raw = 8'h00; en_wr = 1'b0; en_wdata = 8'h00; vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", vec_valid, 0);
    chk("rst_id", vec_id, 0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_irq_en", irq_en, 8'h00);
    chk("rst_pe_in_n", pe_in_n, 8'hFF);
    chk("rst_pe_en_n", pe_en_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle with everything enabled and no requests.
    step(8'h00, 1'b1, 8'hFF, 1'b0);
    chk("en_write", irq_en, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b0, 8'h00, 1'b1);
      chk("idle_valid", vec_valid, 0);
      chk("idle_pe_in_n", pe_in_n, 8'hFF);
      chk("idle_pe_en_n", pe_en_n, 0);
    end

    // Single edge request on channel 3.
    tbl.push_back(mk(8'h08,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h08,0,8'hF7));
    tbl.push_back(mk(8'h00,0,8'h00,1, 1,3,8'h08,1,8'hF7));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,1,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    // Channels 2 and 6 together: 6 first, then 2 two cycles after the ack.
    tbl.push_back(mk(8'h44,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h44,0,8'hBB));
    tbl.push_back(mk(8'h00,0,8'h00,1, 1,6,8'h44,1,8'hBB));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h04,1,8'hFB));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h04,0,8'hFB));
    tbl.push_back(mk(8'h00,0,8'h00,1, 1,2,8'h04,1,8'hFB));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,1,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    // Disabled channel 1 stays pending, then arbitrates once enabled.
    tbl.push_back(mk(8'h00,1,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h02,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h02,0,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h02,0,8'hFF));
    tbl.push_back(mk(8'h00,1,8'h02,1, 0,0,8'h02,0,8'hFD));
    tbl.push_back(mk(8'h00,0,8'h00,1, 1,1,8'h02,1,8'hFD));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,1,8'hFF));
    tbl.push_back(mk(8'h00,0,8'h00,1, 0,0,8'h00,0,8'hFF));

    foreach (tbl[i]) begin
      step(tbl[i].raw, tbl[i].enw, tbl[i].enwd, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), vec_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].epend);
      chk($sformatf("tbl%0d_pe_en_n", i), pe_en_n, tbl[i].epen);
      chk($sformatf("tbl%0d_pe_in_n", i), pe_in_n, tbl[i].epin);
      if (tbl[i].ev) chk($sformatf("tbl%0d_id", i), vec_id, tbl[i].eid);
    end

    // Level channel 5 held high: vector 5 every 3 cycles.
    step(8'h00, 1'b1, 8'hFF, 1'b1);
    last_rise = -1; rises = 0; prev_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(8'h20, 1'b0, 8'h00, 1'b1);
      if (vec_valid) chk("lvl_id", vec_id, 5);
      if (vec_valid && !prev_valid) begin
        if (last_rise >= 0) chk("lvl_period", c - last_rise, 3);
        last_rise = c;
        rises++;
      end
      prev_valid = vec_valid;
    end
    chk("lvl_enough_vectors", (rises >= 10), 1);
    for (int c = 0; c < 15; c++) step(8'h00, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step(8'h00, 1'b0, 8'h00, 1'b1);
      chk("lvl_drop_valid", vec_valid, 0);
    end
    chk("lvl_drop_pending", pending, 8'h00);

    // Channel 4 held presented; a higher-priority arrival must not disturb it.
    step(8'h10, 1'b0, 8'h00, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(8'h00, 1'b0, 8'h00, 1'b0);
      got = vec_valid;
    end
    chk("hold_valid_seen", got, 1);
    chk("hold_id4", vec_id, 4);
    step(8'h80, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 6; c++) step(8'h00, 1'b0, 8'h00, 1'b0);
    chk("hold_valid", vec_valid, 1);
    chk("hold_id_stable", vec_id, 4);
    chk("hold_pending", pending, 8'h90);
    chk("hold_pe_en_n", pe_en_n, 1);
    chk("hold_pe_in_n", pe_in_n, 8'h6F);

    // Asynchronous reset mid-PRESENT.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", vec_valid, 0);
    chk("arst_pending", pending, 8'h00);
    chk("arst_irq_en", irq_en, 8'h00);
    chk("arst_id", vec_id, 0);
    chk("arst_pe_in_n", pe_in_n, 8'hFF);
    chk("arst_pe_en_n", pe_en_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
